md_unit: RTL
============

Name: md_unit

Overview:
- Parametrised multiply/divide unit that sits in the Execute stage of the 5-stage pipeline, alongside the ALU.
- Owns the HI/LO registers and runs multi-cycle mult/multu/div/divu with configurable latency.
- Raises a stall request to the stall/forward unit when a Decode-stage instruction needs the unit while it is occupied.
- mfhi/mflo read HI/LO through hi_out/lo_out; forwarding is not required because HI/LO update only after the busy window ends.

Parameters:
- WIDTH, 32, operand and HI/LO width; minimum 2.
- MULT_LAT, 5, busy cycles for mult/multu; minimum 1.
- DIV_LAT, 10, busy cycles for div/divu; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is mult/multu/div/divu; qualifies op.
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, others no-op.
- wr_en  in  1  E-stage instruction is mthi/mtlo; qualifies op.
- a  in  WIDTH  rs operand, already forwarded.
- b  in  WIDTH  rt operand, already forwarded.
- d_md_use  in  1  D-stage instruction is any mult/div/mthi/mtlo/mfhi/mflo.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- md_stall  out  1  stall request = d_md_use & (start | busy).

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, FSM IDLE, latched operands=0. md_stall is combinational and follows its inputs.
- FSM states are IDLE and RUN.
- IDLE, start=1 at edge of cycle t:
  - Latch a, b and op.
  - Load counter with MULT_LAT (op 0/1) or DIV_LAT (op 2/3). Counter width $clog2(max(MULT_LAT,DIV_LAT)+1).
  - Go to RUN; busy=1 from cycle t+1.
- RUN, each edge: counter decrements.
  - At the edge where counter==1: write HI/LO, busy=0, return to IDLE.
  - busy is therefore high exactly LAT cycles; new HI/LO are visible from cycle t+LAT+1.
- Results are computed from the latched operands only; a/b changes during RUN have no effect.
- Arithmetic, full 2*WIDTH product:
  - mult: signed product; HI = upper WIDTH bits, LO = lower.
  - multu: unsigned product, same split.
- Arithmetic, division:
  - div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div with a = most-negative value and b = -1: LO = most-negative value, HI = 0.
- Divide by zero (latched b==0): full latency still elapses; HI and LO are unchanged.
- mthi/mtlo (wr_en=1, op 4/5, IDLE, start=0): write a into HI or LO at the edge, with no busy. hi_out/lo_out show the new value next cycle.
- Ignored inputs:
  - start=1 or wr_en=1 while busy=1 is ignored. The stall unit guarantees this does not occur; the bench checks that state is unaffected.
  - start and wr_en both 1: start wins, wr_en ignored.
  - Undefined op codes: no state change, no busy.
- md_stall is purely combinational. It covers the start cycle itself (start=1 with d_md_use=1) so the next md instruction cannot enter E during the first RUN cycle.
- Reset asserted mid-RUN: immediate abort, all state as above, no partial HI/LO write.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3, start cycle t -> busy high cycles t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 -> LO=3, HI=1.
- Preload HI=0x11, LO=0x22 via mthi/mtlo; then div a=5, b=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged. div a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- d_md_use=1 held while start pulses at t -> md_stall=1 cycles t..t+5 (MULT_LAT=5), 0 at t+6. With d_md_use=0 -> md_stall=0 throughout.
- Second start and wr_en(mthi, a=0xDEAD) injected while busy -> ignored; final HI/LO equal the first op's result.
- reset=0 asserted asynchronously mid-RUN (between edges) -> busy, HI, LO read 0 immediately. After release, mult a=4, b=5 -> LO=20, HI=0. Rerun with WIDTH=16, MULT_LAT=1, DIV_LAT=3: mult 0x8000*0x8000 -> HI=0x4000, LO=0x0000 after 1 busy cycle.

Source files
------------

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage request, stall and HI/LO result bundle for md_unit
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic             wr_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             d_md_use;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             md_stall;

    modport master (
        output start, op, wr_en, a, b, d_md_use,
        input  hi_out, lo_out, busy, md_stall
    );

    modport slave (
        input  start, op, wr_en, a, b, d_md_use,
        output hi_out, lo_out, busy, md_stall
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle mult/multu/div/divu unit owning HI/LO, with D-stage stall request
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, a_q, b_q;
    logic             op_div, op_uns;
    logic             launch, mt_write, finish;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, q_res, r_res;

    assign launch   = (state == IDLE) && bus.start && !bus.op[2];
    assign mt_write = (state == IDLE) && !bus.start && bus.wr_en &&
                      ((bus.op == 3'd4) || (bus.op == 3'd5));
    assign finish   = (state == RUN) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = RUN;
            RUN:     if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state == RUN);
        bus.md_stall = bus.d_md_use && (bus.start || (state == RUN));
    end

    assign bus.hi_out = hi;
    assign bus.lo_out = lo;

    // Signed divide runs on magnitudes; -MIN wraps to MIN, which is the correct unsigned magnitude
    always_comb begin
        prod_s  = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_neg   = !op_uns && a_q[WIDTH-1];
        b_neg   = !op_uns && b_q[WIDTH-1];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        divisor = (b_mag == '0) ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        q_res   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r_res   = a_neg ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_div <= 1'b0;
            op_uns <= 1'b0;
            cnt    <= '0;
        end else if (launch) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            op_div <= bus.op[1];
            op_uns <= bus.op[0];
            cnt    <= bus.op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (finish) begin
                if (!op_div) begin
                    {hi, lo} <= op_uns ? prod_u : prod_s;
                end else if (b_q != '0) begin
                    hi <= r_res;
                    lo <= q_res;
                end
            end
        end else if (mt_write) begin
            if (bus.op[0]) lo <= bus.a;
            else           hi <= bus.a;
        end
    end
endmodule
